aux_uart_controller_rf_transceiver: RTL and testbench

Drives the UART-side AUX handshake for the RF transceiver. It sits directly upstream of the mode controller and produces the `AUX_uart_ctrl` busy flag that gates mode switching. It enforces the E32-style pre-notification delay before bytes are streamed to the MCU and the post-stream delay before AUX is released. It also merges all AUX sources into the registered `AUX` pin.

---
 rtl/rf_transceiver_pkg.sv | 22 ++
 rtl/aux_uart_controller_rf_transceiver.sv | 120 ++++++++++++
 tb/tb_aux_uart_controller_rf_transceiver.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rf_transceiver_pkg.sv
// Shared definitions for the RF transceiver control blocks.
//   - AUX FSM state encodings (2-bit) and the matching enum type
//   - Default AUX pre/post delays; the mode controller's END_MODE_SWITCH
//     uses the same constants so both paths agree on the E32 timing.
package rf_transceiver_pkg;

    localparam logic [1:0] AUX_ST_IDLE      = 2'd0;
    localparam logic [1:0] AUX_ST_PRE_WAIT  = 2'd1;
    localparam logic [1:0] AUX_ST_STREAM    = 2'd2;
    localparam logic [1:0] AUX_ST_POST_WAIT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = AUX_ST_IDLE,
        S_PRE_WAIT  = AUX_ST_PRE_WAIT,
        S_STREAM    = AUX_ST_STREAM,
        S_POST_WAIT = AUX_ST_POST_WAIT
    } aux_state_e;

    localparam int AUX_PRE_DELAY_DEF  = 2000;
    localparam int AUX_POST_DELAY_DEF = 2000;

endpackage

// File: rtl/aux_uart_controller_rf_transceiver.sv
// UART-side AUX handshake for the RF transceiver.
// Holds AUX low for PRE_DELAY cycles before bytes stream to the MCU and for
// POST_DELAY cycles after the stream ends, and merges all AUX sources into
// the registered AUX pin.
//
// Ports:
//   internal_clk    - clock
//   rst_n           - asynchronous active-low reset
//   rx_pending      - RX buffer holds data for the MCU
//   tx_pending      - TX buffer holds MCU data not yet sent over RF
//   uart_tx_idle    - UART transmitter to the MCU has no byte in flight
//   AUX_mode_ctrl   - mode controller AUX contribution (0 = switch/init busy)
//   AUX_state_ctrl  - RF state controller AUX contribution
//   uart_tx_enable  - UART transmitter may pull bytes from the RX buffer
//   AUX_uart_ctrl   - 1 = UART path idle, 0 = busy
//   AUX             - registered AND of the three AUX contributions
module aux_uart_controller_rf_transceiver
    import rf_transceiver_pkg::*;
#(
    parameter int   PRE_DELAY    = AUX_PRE_DELAY_DEF,
    parameter int   POST_DELAY   = AUX_POST_DELAY_DEF,
    parameter logic AUX_POWER_ON = 1'b0
) (
    input  logic internal_clk,
    input  logic rst_n,
    input  logic rx_pending,
    input  logic tx_pending,
    input  logic uart_tx_idle,
    input  logic AUX_mode_ctrl,
    input  logic AUX_state_ctrl,
    output logic uart_tx_enable,
    output logic AUX_uart_ctrl,
    output logic AUX
);

    localparam int MAX_DELAY = (PRE_DELAY > POST_DELAY) ? PRE_DELAY : POST_DELAY;
    localparam int CW        = $clog2(MAX_DELAY + 1);

    // Terminal counts; the counter stops here and never wraps.
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_DELAY - 1);
    localparam logic [CW-1:0] POST_LAST = CW'(POST_DELAY - 1);

    aux_state_e    state;
    logic [CW-1:0] cnt;

    // AUX_uart_ctrl is only ever raised in IDLE (or on the POST_WAIT->IDLE
    // transition); it is dropped when leaving IDLE and simply held low in
    // every other state.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            uart_tx_enable <= 1'b0;
            AUX_uart_ctrl  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    // A new RX request wins over the tx_pending update.
                    if (rx_pending & AUX_mode_ctrl) begin
                        state         <= S_PRE_WAIT;
                        cnt           <= '0;
                        AUX_uart_ctrl <= 1'b0;
                    end else begin
                        AUX_uart_ctrl <= ~tx_pending;
                    end
                end
                S_PRE_WAIT: begin
                    // rx_pending is ignored here: the full delay always runs.
                    if (cnt == PRE_LAST) begin
                        state          <= S_STREAM;
                        cnt            <= '0;
                        uart_tx_enable <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STREAM: begin
                    if (~rx_pending & uart_tx_idle) begin
                        state          <= S_POST_WAIT;
                        cnt            <= '0;
                        uart_tx_enable <= 1'b0;
                    end else begin
                        uart_tx_enable <= 1'b1;
                    end
                end
                S_POST_WAIT: begin
                    // AUX never rose, so new data goes straight back to
                    // streaming without another pre-notification delay.
                    if (rx_pending) begin
                        state          <= S_STREAM;
                        cnt            <= '0;
                        uart_tx_enable <= 1'b1;
                    end else if (cnt == POST_LAST) begin
                        state         <= S_IDLE;
                        cnt           <= '0;
                        AUX_uart_ctrl <= ~tx_pending;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    cnt            <= '0;
                    uart_tx_enable <= 1'b0;
                    AUX_uart_ctrl  <= 1'b1;
                end
            endcase
        end
    end

    // Pin merge uses the registered AUX_uart_ctrl, so it lags by one cycle.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            AUX <= AUX_POWER_ON;
        end else begin
            AUX <= AUX_mode_ctrl & AUX_state_ctrl & AUX_uart_ctrl;
        end
    end

endmodule

// File: tb/tb_aux_uart_controller_rf_transceiver.sv
// Scoreboard bench: the driver pushes the hand-computed {en, uart_ctrl, aux}
// expected after each clock edge; the monitor pops and compares after it.
module tb_aux_uart_controller_rf_transceiver;

    logic internal_clk = 1'b0;
    logic rst_n        = 1'b0;
    logic rx_pending   = 1'b0;
    logic tx_pending   = 1'b0;
    logic uart_tx_idle = 1'b1;
    logic AUX_mode_ctrl  = 1'b1;
    logic AUX_state_ctrl = 1'b1;
    logic uart_tx_enable, AUX_uart_ctrl, AUX;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] e;
        string      nm;
    } exp_t;
    exp_t q[$];

    aux_uart_controller_rf_transceiver #(
        .PRE_DELAY   (4),
        .POST_DELAY  (3),
        .AUX_POWER_ON(1'b0)
    ) dut (
        .internal_clk  (internal_clk),
        .rst_n         (rst_n),
        .rx_pending    (rx_pending),
        .tx_pending    (tx_pending),
        .uart_tx_idle  (uart_tx_idle),
        .AUX_mode_ctrl (AUX_mode_ctrl),
        .AUX_state_ctrl(AUX_state_ctrl),
        .uart_tx_enable(uart_tx_enable),
        .AUX_uart_ctrl (AUX_uart_ctrl),
        .AUX           (AUX)
    );

    always #5 internal_clk = ~internal_clk;

    task automatic check(input string nm, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: en/uart_ctrl/aux got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    // Push the expectation for the coming edge, then move to the next negedge.
    task automatic tick(input logic [2:0] e, input string nm);
        exp_t x;
        x.e  = e;
        x.nm = nm;
        q.push_back(x);
        @(negedge internal_clk);
    endtask

    task automatic ticks(input int n, input logic [2:0] e, input string nm);
        for (int i = 0; i < n; i++) tick(e, nm);
    endtask

    // Monitor
    initial begin
        exp_t x;
        forever begin
            @(posedge internal_clk);
            #2;
            if (q.size() != 0) begin
                x = q.pop_front();
                check(x.nm, {uart_tx_enable, AUX_uart_ctrl, AUX}, x.e);
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge internal_clk);
        // Reset state and release: AUX rises one edge after release
        ticks(2, 3'b010, "reset_state");
        rst_n = 1'b1;
        tick(3'b011, "reset_release");
        ticks(2, 3'b011, "idle");

        // Single RX stream
        rx_pending = 1'b1;
        tick(3'b001, "rx_start");
        ticks(3, 3'b000, "pre_wait");
        tick(3'b100, "stream_enable");
        ticks(2, 3'b100, "stream");
        rx_pending = 1'b0; uart_tx_idle = 1'b0;
        tick(3'b100, "stream_byte_in_flight");
        uart_tx_idle = 1'b1;
        tick(3'b000, "stream_end");
        ticks(2, 3'b000, "post_wait");
        tick(3'b010, "aux_release");
        tick(3'b011, "aux_pin_high");

        // Re-arm during POST_WAIT
        rx_pending = 1'b1;
        tick(3'b001, "rearm_rx_start");
        ticks(3, 3'b000, "rearm_pre");
        ticks(2, 3'b100, "rearm_stream");
        rx_pending = 1'b0;
        tick(3'b000, "rearm_post_entry");
        rx_pending = 1'b1;
        tick(3'b100, "rearm_back_to_stream");
        rx_pending = 1'b0;
        tick(3'b000, "rearm_post2_entry");
        ticks(2, 3'b000, "rearm_post2_full");
        tick(3'b010, "rearm_release");
        tick(3'b011, "rearm_pin_high");

        // TX busy
        tx_pending = 1'b1;
        tick(3'b001, "tx_busy_ctrl_low");
        tick(3'b000, "tx_busy_pin_low");
        rx_pending = 1'b1;
        tick(3'b000, "tx_rx_start");
        ticks(3, 3'b000, "tx_pre");
        tick(3'b100, "tx_stream");
        rx_pending = 1'b0;
        tick(3'b000, "tx_post_entry");
        ticks(2, 3'b000, "tx_post");
        ticks(2, 3'b000, "tx_post_end_stays_busy");
        tx_pending = 1'b0;
        tick(3'b010, "tx_clear_idle");
        tick(3'b011, "tx_clear_pin");

        // Mode-switch gating
        AUX_mode_ctrl = 1'b0; rx_pending = 1'b1;
        ticks(4, 3'b010, "mode_held_off");
        AUX_mode_ctrl = 1'b1;
        tick(3'b001, "mode_release_start");
        ticks(3, 3'b000, "mode_pre");
        ticks(2, 3'b100, "mode_stream");

        // Reset during STREAM: outputs drop without a clock edge
        rst_n = 1'b0;
        #1;
        check("async_reset", {uart_tx_enable, AUX_uart_ctrl, AUX}, 3'b010);
        @(negedge internal_clk);
        tick(3'b010, "reset_hold");
        rst_n = 1'b1; rx_pending = 1'b0;
        tick(3'b011, "restart_idle");
        rx_pending = 1'b1;
        tick(3'b001, "restart_rx_start");
        tick(3'b000, "restart_pre");

        @(posedge internal_clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending expectations got %0d expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
